// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell plus a carry flop, LSB first over WIDTH clocks.
// Results, carry and signed overflow are published only when the last bit is done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // state  | meaning
    // S_IDLE | waiting for start; operands latched on the accepting edge
    // S_RUN  | one bit per clock, WIDTH clocks
    // S_DONE | single-cycle done pulse, start ignored

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             s_bit;
    logic             c_nxt;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_bit) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: b is inverted on load and the carry starts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {s_bit, res_sh[WIDTH-1:1]};
                    carry  <= c_nxt;
                    cnt    <= cnt + CW'(1);
                    // On the MSB step, carry still holds the carry into the MSB.
                    if (last_bit) begin
                        sum      <= {s_bit, res_sh[WIDTH-1:1]};
                        cout     <= c_nxt;
                        overflow <= carry ^ c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == S_RUN);
            done <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases and random ops on an 8-bit unit, exhaustive sweep on a 2-bit unit,
// all checked against an integer-arithmetic reference model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, sub8, busy8, done8, cout8, ov8;
    logic [7:0] a8, b8, sum8;
    logic       start2, sub2, busy2, done2, cout2, ov2;
    logic [1:0] a2, b2, sum2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last8 = '0;
    logic [31:0] last2 = '0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .overflow(ov2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry/borrow, signed range for overflow.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, output logic [31:0] es, output logic ec,
                                  output logic eo);
        longint m  = longint'(1) << w;
        longint ua = longint'(av);
        longint ub = longint'(bv);
        longint r  = sv ? ua - ub : ua + ub;
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint sr = sv ? sa - sb : sa + sb;
        es = 32'(((r % m) + m) % m);
        ec = sv ? (ua >= ub) : (r >= m);
        eo = (sr < -(m / 2)) || (sr >= m / 2);
    endfunction

    task automatic drive(input int w, input logic [31:0] av, input logic [31:0] bv,
                         input logic sv, input logic st);
        if (w == 8) begin
            a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; start8 = st;
        end else begin
            a2 = av[1:0]; b2 = bv[1:0]; sub2 = sv; start2 = st;
        end
    endtask

    function automatic logic get_busy(input int w);
        return (w == 8) ? busy8 : busy2;
    endfunction
    function automatic logic get_done(input int w);
        return (w == 8) ? done8 : done2;
    endfunction
    function automatic logic [31:0] get_sum(input int w);
        return (w == 8) ? 32'(sum8) : 32'(sum2);
    endfunction
    function automatic logic get_cout(input int w);
        return (w == 8) ? cout8 : cout2;
    endfunction
    function automatic logic get_ov(input int w);
        return (w == 8) ? ov8 : ov2;
    endfunction

    // One accepted operation; inputs are scrambled right after acceptance to prove they were latched.
    task automatic op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv);
        logic [31:0] es, prev;
        logic        ec, eo, held, junk_s;
        int          lat, bcnt;
        model(w, av, bv, sv, es, ec, eo);
        prev = (w == 8) ? last8 : last2;
        drive(w, av, bv, sv, 1'b1);
        @(posedge clk); #1;
        junk_s = 1'($urandom_range(0, 1));
        drive(w, $urandom, $urandom, junk_s, 1'b0);
        lat = 0; bcnt = 0; held = 1'b1;
        for (int i = 1; i <= w + 4; i++) begin
            if (get_busy(w)) bcnt++;
            if (get_sum(w) !== prev) held = 1'b0;
            @(posedge clk); #1;
            if (get_done(w)) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, w);
        check("busy_cycles", bcnt, w);
        check("sum_held", held, 1);
        check("busy_at_done", get_busy(w), 0);
        check("sum", get_sum(w), es);
        check("cout", get_cout(w), ec);
        check("overflow", get_ov(w), eo);
        @(posedge clk); #1;
        check("done_pulse", get_done(w), 0);
        if (w == 8) last8 = es; else last2 = es;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        logic seen;
        reset = 1'b1;
        drive(8, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        check("rst_ov", ov8, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        op(8, 'h7F, 'h01, 0);
        check("t1_sum", sum8, 'h80);
        check("t1_ov", ov8, 1);
        op(8, 'hFF, 'h01, 0);
        check("t2_cout", cout8, 1);
        op(8, 'h00, 'h00, 0);
        op(8, 'h05, 'h07, 1);
        check("t3_sum", sum8, 'hFE);
        op(8, 'h80, 'h01, 1);
        check("t3_ov", ov8, 1);

        // Start held high through RUN with new operands; must be ignored.
        drive(8, 'h10, 'h20, 0, 1);
        @(posedge clk); #1;
        drive(8, 'hAA, 'h55, 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(8, 'hFF, 'hFF, 1, 1);
        @(posedge clk); #1;
        drive(8, 'hFF, 'hFF, 1, 0);
        lat = 0;
        for (int i = 4; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        check("t4_latency", lat, 8);
        check("t4_sum", sum8, 'h30);
        check("t4_cout", cout8, 0);
        check("t4_ov", ov8, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_queue", busy8, 0);
        check("t4_sum_held", sum8, 'h30);
        last8 = 'h30;

        // Reset in the fourth RUN cycle aborts the op.
        drive(8, 'h33, 'h44, 0, 1);
        @(posedge clk); #1;
        drive(8, 'h33, 'h44, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_pre", busy8, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t5_busy", busy8, 0);
        check("t5_sum", sum8, 0);
        check("t5_cout", cout8, 0);
        check("t5_ov", ov8, 0);
        start8 = 1'b1;
        @(posedge clk); #1;
        check("t5_reset_wins", busy8, 0);
        start8 = 1'b0;
        reset  = 1'b0;
        last8  = '0;
        last2  = '0;
        seen   = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen = 1'b1;
        end
        check("t5_no_done", seen, 0);
        op(8, 'h01, 'h02, 0);
        check("t5_sum_new", sum8, 'h03);

        for (int av = 0; av < 4; av++)
            for (int bv = 0; bv < 4; bv++)
                for (int sv = 0; sv < 2; sv++)
                    op(2, 32'(av), 32'(bv), 1'(sv));

        repeat (40) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial add/subtract unit built around a single full-adder cell and a carry flip-flop. It processes one bit per clock, LSB first, over WIDTH cycles. It produces an unsigned carry/borrow flag and a signed overflow flag. It replaces wide combinational ripple adders in score and position arithmetic where logic area matters more than latency, and uses a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  mode, latched with start: 0 = a+b, 1 = a-b
a  input  WIDTH  operand A, latched with start
b  input  WIDTH  operand B, latched with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result is valid
sum  output  WIDTH  result, held until next accepted start completes
cout  output  1  carry out; in subtract mode, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed two's-complement overflow of the operation

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0. Internal shift registers, bit counter and carry are all cleared.
- States:
  - IDLE: waits for start. If start=1 at edge k: latch a, latch b (or ~b if sub=1), set carry=sub, clear bit counter, go to RUN.
  - RUN: at each edge, compute s = a_sh[0]^b_sh[0]^carry and carry' = a_sh[0]&b_sh[0] | carry&(a_sh[0]^b_sh[0]).
    - Shift a_sh and b_sh right by one. Shift s into the result register MSB.
    - Record the carry into the MSB on the step with counter=WIDTH-1.
    - Counter increments. On the step with counter=WIDTH-1, go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Result update: sum, cout and overflow update only at the edge entering DONE (edge k+WIDTH). They are held otherwise, so partial results are never visible on sum.
  - cout = final carry.
  - overflow = carry-into-MSB XOR final carry.
- Latency: busy=1 during cycles k+1..k+WIDTH. done=1 only in the cycle following edge k+WIDTH. Start-to-done is WIDTH+1 edges.
- Handshake:
  - start is ignored in RUN and DONE; no queuing.
  - Back-to-back throughput is one operation per WIDTH+2 cycles.
  - Operand or sub changes after acceptance have no effect.
- Subtract is a + ~b + 1 via initial carry=1. Result wraps modulo 2^WIDTH.
- Reset during RUN or DONE: abort immediately, apply reset values. done is not pulsed for the aborted operation.
- reset and start high together: reset wins.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. WIDTH=8, add 0x7F+0x01, start one cycle -> busy high for 8 cycles, done pulse 9 edges after start, sum=0x80, cout=0, overflow=1.
2. Add 0xFF+0x01 -> sum=0x00, cout=1, overflow=0. Add 0x00+0x00 -> sum=0x00, cout=0, overflow=0.
3. sub=1, 0x05-0x07 -> sum=0xFE, cout=0 (borrow), overflow=0. sub=1, 0x80-0x01 -> sum=0x7F, cout=1, overflow=1.
4. Accept 0x10+0x20, then pulse start with 0xAA+0x55 and change a/b/sub at cycle 3 of RUN -> second start ignored, result 0x30, sum held at 0x30 until next accepted op completes.
5. Assert reset at RUN cycle 4, then start 0x01+0x02 -> no done from aborted op, outputs zero after reset, new op yields sum=0x03 after WIDTH+1 edges.
6. WIDTH=2, exhaustive sweep of a, b, sub (32 ops, back-to-back as soon as IDLE) -> each result, cout and overflow match the 2-bit arithmetic golden model.
